// File: rtl/i2c_write_nbyte_master_pkg.sv
// Shared types and helpers for the parametrised I2C write master.
// States, frame sizing and the byte-select helper live here so every file agrees on them.
package i2c_master_pkg;

    localparam int MAX_FRAME_BYTES = 13;
    localparam int FRAME_W         = 8 * MAX_FRAME_BYTES;
    localparam int TICKS_PER_BIT   = 3;
    localparam logic [2:0] LAST_BIT = 3'd7;

    typedef enum logic [3:0] {
        S_IDLE, S_STA_A, S_STA_B,
        S_B_LOW, S_B_SET, S_B_HIGH,
        S_A_LOW, S_A_REL, S_A_HIGH,
        S_STO_A, S_STO_B, S_STO_C,
        S_GAP
    } state_t;

    function automatic int wlen_width(input int max_data);
        return (max_data < 1) ? 1 : $clog2(max_data + 1);
    endfunction

    function automatic int data_width(input int max_data);
        return (max_data < 1) ? 8 : 8 * max_data;
    endfunction

    // Byte 0 of the frame is the address, then pointer bytes MS first, then payload.
    function automatic logic [7:0] sel_byte(input logic [FRAME_W-1:0] frame, input logic [3:0] idx);
        return frame[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/i2c_write_nbyte_master_if.sv
// Sequencer/pad-side bundle of the I2C write master.
// The master modport is the DUT view; the slave modport is the sequencer/pad view.
interface i2c_write_nbyte_master_if
    import i2c_master_pkg::*;
#(
    parameter int PTR_BYTES = 2,
    parameter int MAX_DATA  = 4
);
    localparam int WLEN_W = wlen_width(MAX_DATA);
    localparam int DATA_W = data_width(MAX_DATA);

    logic                   GO;
    logic [7:0]             SLAVE_ADDRESS;
    logic [8*PTR_BYTES-1:0] POINTER;
    logic [DATA_W-1:0]      WDATA;
    logic [WLEN_W-1:0]      WLEN;
    logic                   SDAI;
    logic                   SDAO;
    logic                   SCLO;
    logic                   END_OK;
    logic                   ACK_OK;
    logic                   NACK_ERR;
    logic [3:0]             BYTE_IDX;

    modport master (
        input  GO, SLAVE_ADDRESS, POINTER, WDATA, WLEN, SDAI,
        output SDAO, SCLO, END_OK, ACK_OK, NACK_ERR, BYTE_IDX
    );

    modport slave (
        output GO, SLAVE_ADDRESS, POINTER, WDATA, WLEN, SDAI,
        input  SDAO, SCLO, END_OK, ACK_OK, NACK_ERR, BYTE_IDX
    );

endinterface

// File: rtl/i2c_write_nbyte_master_tick_gen.sv
// Free-running phase-tick divider: one-cycle tick every CLK_DIV clocks.
module i2c_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic PT_CK,
    input  logic RESET_N,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter with registered tick pulse.
    always_ff @(posedge PT_CK) begin
        if (!RESET_N) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/i2c_write_nbyte_master.sv
// I2C write master: START, address, pointer bytes, payload bytes, STOP, with NACK abort.
// Optional I2C_WAKE_POLL_EN: address NACKs trigger STOP/gap/restart polling up to MAX_RETRY times.
module i2c_write_nbyte_master
    import i2c_master_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int PTR_BYTES = 2,
    parameter int MAX_DATA  = 4,
    parameter int MAX_RETRY = 15,
    parameter int RETRY_GAP = 8
) (
    input  logic                      PT_CK,
    input  logic                      RESET_N,
    i2c_write_nbyte_master_if.master  bus
);
    localparam int WLEN_W = wlen_width(MAX_DATA);
    localparam logic [WLEN_W-1:0] MAX_DATA_W = WLEN_W'(MAX_DATA);
    localparam logic [3:0] PTR_BYTES_4 = 4'(PTR_BYTES);

    logic               tick_s;
    logic [FRAME_W-1:0] frame_s;
    logic [WLEN_W-1:0]  n_data_s;
    logic [3:0]         last_idx_s;

    state_t             state_r;
    logic [FRAME_W-1:0] frame_r;
    logic [3:0]         last_idx_r;
    logic [3:0]         byte_idx_r;
    logic [2:0]         bit_cnt_r;
    logic [7:0]         sh_r;
    logic               armed_r;
    logic               sdao_r;
    logic               sclo_r;
    logic               end_ok_r;
    logic               ack_ok_r;
    logic               nack_err_r;
`ifdef I2C_WAKE_POLL_EN
    localparam logic [7:0] MAX_RETRY_8 = 8'(MAX_RETRY);
    localparam logic [7:0] GAP_LAST_8  = 8'((RETRY_GAP > 0) ? RETRY_GAP - 1 : 0);
    logic [7:0]         retry_cnt_r;
    logic [7:0]         gap_cnt_r;
    logic               retry_pend_r;
`endif

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .PT_CK   (PT_CK),
        .RESET_N (RESET_N),
        .tick    (tick_s)
    );

    // Assemble the outgoing frame and the clamped index of its last byte.
    always_comb begin
        frame_s = '0;
        frame_s[7:0] = bus.SLAVE_ADDRESS;
        for (int p = 0; p < PTR_BYTES; p++) begin
            frame_s[8*(p+1) +: 8] = bus.POINTER[8*(PTR_BYTES-1-p) +: 8];
        end
        for (int k = 0; k < MAX_DATA; k++) begin
            frame_s[8*(PTR_BYTES+1+k) +: 8] = bus.WDATA[8*k +: 8];
        end
        if (bus.WLEN > MAX_DATA_W) begin
            n_data_s = MAX_DATA_W;
        end else begin
            n_data_s = bus.WLEN;
        end
        last_idx_s = PTR_BYTES_4 + 4'(n_data_s);
    end

    // Bus sequencer; line drives are registered alongside the state they belong to.
    always_ff @(posedge PT_CK) begin
        if (!RESET_N) begin
            state_r    <= S_IDLE;
            frame_r    <= '0;
            last_idx_r <= 4'd0;
            byte_idx_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            sh_r       <= 8'd0;
            armed_r    <= 1'b1;
            sdao_r     <= 1'b1;
            sclo_r     <= 1'b1;
            end_ok_r   <= 1'b1;
            ack_ok_r   <= 1'b0;
            nack_err_r <= 1'b0;
`ifdef I2C_WAKE_POLL_EN
            retry_cnt_r  <= 8'd0;
            gap_cnt_r    <= 8'd0;
            retry_pend_r <= 1'b0;
`endif
        end else if (tick_s) begin
            case (state_r)
                S_IDLE: begin
                    if (!bus.GO) begin
                        armed_r <= 1'b1;
                    end else if (armed_r) begin
                        armed_r    <= 1'b0;
                        end_ok_r   <= 1'b0;
                        ack_ok_r   <= 1'b0;
                        nack_err_r <= 1'b0;
                        frame_r    <= frame_s;
                        last_idx_r <= last_idx_s;
                        byte_idx_r <= 4'd0;
                        bit_cnt_r  <= 3'd0;
                        sh_r       <= bus.SLAVE_ADDRESS;
                        sdao_r     <= 1'b0;
                        sclo_r     <= 1'b1;
                        state_r    <= S_STA_A;
`ifdef I2C_WAKE_POLL_EN
                        retry_cnt_r  <= 8'd0;
                        retry_pend_r <= 1'b0;
`endif
                    end
                end
                S_STA_A: begin
                    sclo_r  <= 1'b0;
                    state_r <= S_STA_B;
                end
                S_STA_B:  state_r <= S_B_LOW;
                S_B_LOW: begin
                    sdao_r  <= sh_r[7];
                    state_r <= S_B_SET;
                end
                S_B_SET: begin
                    sclo_r  <= 1'b1;
                    state_r <= S_B_HIGH;
                end
                S_B_HIGH: begin
                    sclo_r <= 1'b0;
                    if (bit_cnt_r == LAST_BIT) begin
                        state_r <= S_A_LOW;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        sh_r      <= {sh_r[6:0], 1'b0};
                        state_r   <= S_B_LOW;
                    end
                end
                S_A_LOW: begin
                    sdao_r  <= 1'b1;
                    state_r <= S_A_REL;
                end
                S_A_REL: begin
                    sclo_r  <= 1'b1;
                    state_r <= S_A_HIGH;
                end
                S_A_HIGH: begin
                    sclo_r <= 1'b0;
                    if (!bus.SDAI && (byte_idx_r != last_idx_r)) begin
                        byte_idx_r <= byte_idx_r + 4'd1;
                        sh_r       <= sel_byte(frame_r, byte_idx_r + 4'd1);
                        bit_cnt_r  <= 3'd0;
                        state_r    <= S_B_LOW;
                    end else begin
                        sdao_r  <= 1'b0;
                        state_r <= S_STO_A;
                        if (bus.SDAI) begin
`ifdef I2C_WAKE_POLL_EN
                            // Only the address byte may be re-polled; data NACKs abort at once.
                            if ((byte_idx_r == 4'd0) && (retry_cnt_r != MAX_RETRY_8)) begin
                                retry_cnt_r  <= retry_cnt_r + 8'd1;
                                retry_pend_r <= 1'b1;
                            end else begin
                                nack_err_r <= 1'b1;
                            end
`else
                            nack_err_r <= 1'b1;
`endif
                        end
                    end
                end
                S_STO_A: begin
                    sclo_r  <= 1'b1;
                    state_r <= S_STO_B;
                end
                S_STO_B: begin
                    sdao_r  <= 1'b1;
                    state_r <= S_STO_C;
                end
                S_STO_C: begin
`ifdef I2C_WAKE_POLL_EN
                    if (retry_pend_r) begin
                        retry_pend_r <= 1'b0;
                        gap_cnt_r    <= 8'd0;
                        state_r      <= S_GAP;
                    end else begin
                        end_ok_r <= 1'b1;
                        ack_ok_r <= ~nack_err_r;
                        state_r  <= S_IDLE;
                    end
`else
                    end_ok_r <= 1'b1;
                    ack_ok_r <= ~nack_err_r;
                    state_r  <= S_IDLE;
`endif
                end
`ifdef I2C_WAKE_POLL_EN
                S_GAP: begin
                    if (gap_cnt_r == GAP_LAST_8) begin
                        byte_idx_r <= 4'd0;
                        bit_cnt_r  <= 3'd0;
                        sh_r       <= sel_byte(frame_r, 4'd0);
                        sdao_r     <= 1'b0;
                        state_r    <= S_STA_A;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 8'd1;
                    end
                end
`endif
                default: begin
                    sdao_r  <= 1'b1;
                    sclo_r  <= 1'b1;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.SDAO     = sdao_r;
    assign bus.SCLO     = sclo_r;
    assign bus.END_OK   = end_ok_r;
    assign bus.ACK_OK   = ack_ok_r;
    assign bus.NACK_ERR = nack_err_r;
    assign bus.BYTE_IDX = byte_idx_r;

endmodule

// File: tb/tb_i2c_write_nbyte_master.sv
// Self-checking bench: a bus-level I2C slave decodes SDA/SCL and is compared to a frame-level model.
module tb_i2c_write_nbyte_master;
    localparam int CLK_DIV   = 2;
    localparam int PTR_BYTES = 2;
    localparam int MAX_DATA  = 4;
    localparam int MAX_RETRY = 15;
    localparam int RETRY_GAP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_write_nbyte_master_if #(.PTR_BYTES(PTR_BYTES), .MAX_DATA(MAX_DATA)) bus ();

    i2c_write_nbyte_master #(
        .CLK_DIV(CLK_DIV), .PTR_BYTES(PTR_BYTES), .MAX_DATA(MAX_DATA),
        .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP)
    ) dut (
        .PT_CK   (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    // Open-drain SDA: the line is low if either side pulls it low.
    logic slave_sda = 1'b1;
    assign bus.SDAI = bus.SDAO & slave_sda;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave-side bus monitor state.
    int   cyc = 0;
    int   starts = 0, stops = 0, bit_n = 0, byte_pos = 0, period = 0, rise_cyc = 0, addr_nacks_seen = 0;
    int   nack_pos = 99, addr_nack_cfg = 0;
    logic in_frame = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1, mon_clear = 1'b0;
    logic [7:0] cur = 8'h00;
    logic [7:0] rxq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_clear) begin
            in_frame = 1'b0; bit_n = 0; byte_pos = 0; slave_sda = 1'b1;
            starts = 0; stops = 0; period = 0; addr_nacks_seen = 0;
            rxq.delete();
        end else if (prev_scl && bus.SCLO && prev_sda && !bus.SDAI) begin
            starts++; in_frame = 1'b1; bit_n = 0; byte_pos = 0;
        end else if (prev_scl && bus.SCLO && !prev_sda && bus.SDAI) begin
            stops++; in_frame = 1'b0;
        end else if (in_frame && !prev_scl && bus.SCLO) begin
            if (bit_n < 8) begin
                cur = {cur[6:0], bus.SDAI};
                if (byte_pos == 0 && bit_n == 1) period = cyc - rise_cyc;
                rise_cyc = cyc;
                bit_n++;
                if (bit_n == 8) rxq.push_back(cur);
            end else begin
                bit_n = 0;
                byte_pos++;
            end
        end else if (in_frame && prev_scl && !bus.SCLO) begin
            if (bit_n == 8) begin
                if (byte_pos == 0 && addr_nacks_seen < addr_nack_cfg) begin
                    slave_sda = 1'b1;
                    addr_nacks_seen++;
                end else begin
                    slave_sda = (byte_pos == nack_pos) ? 1'b1 : 1'b0;
                end
            end else begin
                slave_sda = 1'b1;
            end
        end
        prev_scl = bus.SCLO;
        prev_sda = bus.SDAI;
    end

    task automatic clear_monitor();
        @(negedge clk); #1 mon_clear = 1'b1;
        @(negedge clk); #1 mon_clear = 1'b0;
    endtask

    task automatic run_xfer(input logic [7:0] addr, input logic [15:0] ptr, input logic [31:0] data,
                            input logic [2:0] wlen, input int nackp, input int addr_nacks, input bit keep_go);
        int n, attempts, cnt, fails;
        bit ok;
        logic [7:0] frame[$];
        logic [7:0] expq[$];
        bus.GO = 1'b0;
        clear_monitor();
        nack_pos = nackp;
        addr_nack_cfg = addr_nacks;
        bus.SLAVE_ADDRESS = addr; bus.POINTER = ptr; bus.WDATA = data; bus.WLEN = wlen;
        bus.GO = 1'b1;
        cnt = 0;
        while (bus.END_OK && cnt < 100) begin @(negedge clk); cnt++; end
        chk("busy", {31'd0, bus.END_OK}, 32'd0);
        cnt = 0;
        while (!bus.END_OK && cnt < 40000) begin @(negedge clk); cnt++; end
        chk("done", {31'd0, bus.END_OK}, 32'd1);
        if (!keep_go) bus.GO = 1'b0;

        // Frame-level reference: which bytes reach the wire, how many STARTs, final status.
        n = 1 + PTR_BYTES + ((int'(wlen) > MAX_DATA) ? MAX_DATA : int'(wlen));
        frame.push_back(addr); frame.push_back(ptr[15:8]); frame.push_back(ptr[7:0]);
        for (int k = 0; k < n - 3; k++) frame.push_back(data[8*k +: 8]);
        attempts = 1; ok = 1'b1; fails = 0;
`ifdef I2C_WAKE_POLL_EN
        fails = addr_nacks;
`endif
        if (fails > MAX_RETRY) begin
            for (int r = 0; r <= MAX_RETRY; r++) expq.push_back(addr);
            attempts = MAX_RETRY + 1; ok = 1'b0;
        end else begin
            for (int r = 0; r < fails; r++) expq.push_back(addr);
            attempts = fails + 1;
            for (int i = 0; i < n; i++) begin
                expq.push_back(frame[i]);
                if (i == nackp) begin ok = 1'b0; break; end
            end
        end

        chk("nbytes", rxq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (i < rxq.size()) chk("byte", {24'd0, rxq[i]}, {24'd0, expq[i]});
        end
        chk("starts", starts, attempts);
        chk("stops", stops, attempts);
        chk("ack_ok", {31'd0, bus.ACK_OK}, {31'd0, ok});
        chk("nack_err", {31'd0, bus.NACK_ERR}, {31'd0, !ok});
        chk("scl_period", period, 3 * CLK_DIV);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int cnt, nackp, an;
        bus.GO = 1'b0; bus.SLAVE_ADDRESS = 8'h00; bus.POINTER = 16'h0000;
        bus.WDATA = 32'h0; bus.WLEN = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_sdao", {31'd0, bus.SDAO}, 32'd1);
        chk("rst_sclo", {31'd0, bus.SCLO}, 32'd1);
        chk("rst_end_ok", {31'd0, bus.END_OK}, 32'd1);
        chk("rst_ack_ok", {31'd0, bus.ACK_OK}, 32'd0);
        chk("rst_nack_err", {31'd0, bus.NACK_ERR}, 32'd0);
        chk("rst_byte_idx", {28'd0, bus.BYTE_IDX}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        run_xfer(8'h6C, 16'h3012, 32'h000000A5, 3'd1, 99, 0, 1'b0);
        run_xfer(8'h6C, 16'h3012, 32'h000000A5, 3'd1, 2, 0, 1'b0);
        run_xfer(8'h6C, 16'h3012, 32'hDEADBEEF, 3'd0, 99, 0, 1'b0);
        run_xfer(8'h6C, 16'h3012, 32'h11223344, 3'd7, 99, 0, 1'b0);
        run_xfer(8'h6C, 16'h3012, 32'h11223344, 3'd4, 0, 0, 1'b0);

        // GO held high after completion must not start a second transfer.
        run_xfer(8'h42, 16'hABCD, 32'h55AA55AA, 3'd2, 99, 0, 1'b1);
        repeat (300) @(negedge clk);
        chk("no_retrig_end", {31'd0, bus.END_OK}, 32'd1);
        chk("no_retrig_starts", starts, 1);
        run_xfer(8'h43, 16'h0102, 32'h0000F00D, 3'd2, 99, 0, 1'b0);

`ifdef I2C_WAKE_POLL_EN
        run_xfer(8'h6C, 16'h3012, 32'h000000A5, 3'd1, 99, 3, 1'b0);
        run_xfer(8'h6C, 16'h3012, 32'h000000A5, 3'd1, 99, 100, 1'b0);
`endif

        for (int t = 0; t < 20; t++) begin
            nackp = ($urandom_range(0, 1) == 0) ? 99 : int'($urandom_range(0, 7));
            an = 0;
`ifdef I2C_WAKE_POLL_EN
            an = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
`endif
            run_xfer(8'($urandom), 16'($urandom), $urandom, 3'($urandom_range(0, 7)), nackp, an, 1'b0);
        end

        // Reset in the middle of the second byte releases both lines on that edge.
        bus.GO = 1'b0;
        clear_monitor();
        nack_pos = 99; addr_nack_cfg = 0;
        bus.SLAVE_ADDRESS = 8'h6C; bus.POINTER = 16'h3012; bus.WDATA = 32'hA5; bus.WLEN = 3'd1;
        bus.GO = 1'b1;
        cnt = 0;
        while (!(byte_pos == 1 && bit_n == 4) && cnt < 2000) begin @(negedge clk); cnt++; end
        chk("rst_reach", {31'd0, (cnt < 2000)}, 32'd1);
        rst_n = 1'b0;
        bus.GO = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_sdao", {31'd0, bus.SDAO}, 32'd1);
        chk("mid_rst_sclo", {31'd0, bus.SCLO}, 32'd1);
        chk("mid_rst_end_ok", {31'd0, bus.END_OK}, 32'd1);
        chk("mid_rst_ack_ok", {31'd0, bus.ACK_OK}, 32'd0);
        chk("mid_rst_nack_err", {31'd0, bus.NACK_ERR}, 32'd0);
        chk("mid_rst_byte_idx", {28'd0, bus.BYTE_IDX}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run_xfer(8'h6C, 16'h3012, 32'h000000A5, 3'd1, 99, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
